// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the 16-bit datapath: FETCH/DECODE/EXEC/MEM/WB
// with variable-latency memory handshakes, error halt and a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_opcode,
  input  logic             i_inst_ready,
  input  logic             i_data_ready,
  output logic             o_inst_req,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic             o_reg_dst,
  output logic             o_alu_src,
  output logic             o_mem_to_reg,
  output logic             o_reg_w,
  output logic             o_mem_r,
  output logic             o_mem_w,
  output logic             o_beq,
  output logic             o_bne,
  output logic             o_j,
  output logic [1:0]       o_alu_op,
  output logic             o_halted,
  output logic [1:0]       o_err_code,
  output logic [CNT_W-1:0] o_retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  ALU_R     = 2'b00;
  localparam logic [1:0]  ALU_CMP   = 2'b01;
  localparam logic [1:0]  ALU_ADDR  = 2'b10;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_wait_cnt;
  logic [1:0]         r_err_code;
  logic [CNT_W-1:0]   r_retire_cnt;
  logic               w_wait_inc;
  logic               w_err_set;
  logic [1:0]         w_err_val;
  logic               w_timed_out;

  logic w_is_ld, w_is_st, w_is_r, w_is_beq, w_is_bne, w_is_j;
  assign w_is_ld  = (i_opcode == 4'b0000);
  assign w_is_st  = (i_opcode == 4'b0001);
  assign w_is_r   = (i_opcode >= 4'b0010) && (i_opcode <= 4'b1001);
  assign w_is_beq = (i_opcode == 4'b1011);
  assign w_is_bne = (i_opcode == 4'b1100);
  assign w_is_j   = (i_opcode == 4'b1101);

  assign w_timed_out = (r_wait_cnt == WAIT_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_wait_inc   = 1'b0;
    w_err_set    = 1'b0;
    w_err_val    = 2'b00;
    o_inst_req   = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_reg_dst    = 1'b0;
    o_alu_src    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_w      = 1'b0;
    o_mem_r      = 1'b0;
    o_mem_w      = 1'b0;
    o_beq        = 1'b0;
    o_bne        = 1'b0;
    o_j          = 1'b0;
    o_alu_op     = ALU_R;
    o_halted     = 1'b0;

    case (r_state)
      S_FETCH: begin
        o_inst_req = 1'b1;
        if (i_inst_ready) begin
          o_ir_we     = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_timed_out) begin
          w_state_nxt = S_HALT;
          w_err_set   = 1'b1;
          w_err_val   = 2'b10;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_is_j) begin
          o_j         = 1'b1;
          o_pc_we     = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (w_is_ld || w_is_st || w_is_r || w_is_beq || w_is_bne) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_HALT;
          w_err_set   = 1'b1;
          w_err_val   = 2'b01;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        if (w_is_r) begin
          o_reg_dst   = 1'b1;
          w_state_nxt = S_WB;
        end else if (w_is_ld || w_is_st) begin
          o_alu_op    = ALU_ADDR;
          o_alu_src   = 1'b1;
          w_state_nxt = S_MEM;
        end else if (w_is_beq || w_is_bne) begin
          // Taken/not-taken is resolved in the datapath; the controller always retires here.
          o_alu_op = ALU_CMP;
          o_beq    = w_is_beq;
          o_bne    = w_is_bne;
          o_pc_we  = 1'b1;
        end
      end
      S_MEM: begin
        o_alu_op  = ALU_ADDR;
        o_alu_src = 1'b1;
        o_mem_r   = w_is_ld;
        o_mem_w   = w_is_st;
        if (!(w_is_ld || w_is_st)) begin
          w_state_nxt = S_FETCH;
        end else if (i_data_ready) begin
          o_pc_we     = w_is_st;
          w_state_nxt = w_is_ld ? S_WB : S_FETCH;
        end else if (w_timed_out) begin
          w_state_nxt = S_HALT;
          w_err_set   = 1'b1;
          w_err_val   = 2'b11;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_WB: begin
        o_reg_w      = 1'b1;
        o_pc_we      = 1'b1;
        o_reg_dst    = w_is_r;
        o_mem_to_reg = w_is_ld;
        w_state_nxt  = S_FETCH;
      end
      S_HALT:  o_halted    = 1'b1;
      default: w_state_nxt = S_FETCH;
    endcase

    // Reset silences every strobe in the same cycle so an aborted instruction commits nothing.
    if (i_rst) begin
      o_inst_req   = 1'b0;
      o_ir_we      = 1'b0;
      o_pc_we      = 1'b0;
      o_reg_dst    = 1'b0;
      o_alu_src    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_reg_w      = 1'b0;
      o_mem_r      = 1'b0;
      o_mem_w      = 1'b0;
      o_beq        = 1'b0;
      o_bne        = 1'b0;
      o_j          = 1'b0;
      o_alu_op     = ALU_R;
      o_halted     = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_err_code   <= 2'b00;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_wait_cnt <= '0;
      else if (w_wait_inc)
        r_wait_cnt <= r_wait_cnt + 16'd1;
      if (w_err_set)
        r_err_code <= w_err_val;
      if (o_pc_we)
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign o_err_code   = i_rst ? 2'b00 : r_err_code;
  assign o_retire_cnt = i_rst ? '0 : r_retire_cnt;

endmodule
